vx_dot8_arb: RTL

VX_DOT8_ARB -- requirements
Module: VX_dot8_arb

---
 rtl/vx_dot8_arb.sv | 129 ++++++++++++
 1 files changed

// File: rtl/vx_dot8_arb.sv
// Round-robin arbiter sharing one dot8 PE among NUM_REQS requesters.
// The PE answers in issue order; an order FIFO steers each result back to its requester.
module vx_dot8_arb #(
  parameter int unsigned NUM_REQS     = 4,
  parameter int unsigned TAG_WIDTH    = 8,
  parameter int unsigned MAX_INFLIGHT = 4,
  localparam int unsigned IdxW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  localparam int unsigned PtrW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1,
  localparam int unsigned CntW = $clog2(MAX_INFLIGHT) + 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQS-1:0]                 req_valid,
  output logic [NUM_REQS-1:0]                 req_ready,
  input  logic [NUM_REQS-1:0][31:0]           req_a,
  input  logic [NUM_REQS-1:0][31:0]           req_b,
  input  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]  req_tag,
  output logic                                pe_req_valid,
  input  logic                                pe_req_ready,
  output logic [31:0]                         pe_req_a,
  output logic [31:0]                         pe_req_b,
  input  logic                                pe_rsp_valid,
  output logic                                pe_rsp_ready,
  input  logic [31:0]                         pe_rsp_data,
  output logic [NUM_REQS-1:0]                 rsp_valid,
  input  logic [NUM_REQS-1:0]                 rsp_ready,
  output logic [31:0]                         rsp_data,
  output logic [TAG_WIDTH-1:0]                rsp_tag,
  output logic [CntW-1:0]                     inflight,
  output logic                                err
);

  logic [IdxW-1:0]      ptr_q;
  logic                 iss_valid_q;
  logic [31:0]          iss_a_q;
  logic [31:0]          iss_b_q;
  logic [CntW-1:0]      inflight_q;
  logic [PtrW-1:0]      wr_ptr_q;
  logic [PtrW-1:0]      rd_ptr_q;
  logic                 err_q;
  logic [IdxW-1:0]      ord_idx_q [MAX_INFLIGHT];
  logic [TAG_WIDTH-1:0] ord_tag_q [MAX_INFLIGHT];

  logic            found;
  logic            can_issue;
  logic            gnt_valid;
  logic [IdxW-1:0] gnt_idx;
  logic            fifo_ne;
  logic [IdxW-1:0] head_idx;
  logic            rsp_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MAX_INFLIGHT - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Slot check uses the registered count only: a same-cycle pop never frees a slot.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    found     = 1'b0;
    gnt_idx   = '0;
    can_issue = reset && (inflight_q < CntW'(MAX_INFLIGHT)) && (!iss_valid_q || pe_req_ready);
    for (int unsigned k = 0; k < NUM_REQS; k++) begin
      cand = (32'(ptr_q) + k) % NUM_REQS;
      if (!found && req_valid[IdxW'(cand)]) begin
        found   = 1'b1;
        gnt_idx = IdxW'(cand);
      end
    end
    gnt_valid = found && can_issue;
    req_ready = '0;
    if (gnt_valid) req_ready[gnt_idx] = 1'b1;
  end

  // Responses with an empty FIFO are accepted and dropped so the PE never wedges.
  always_comb begin
    fifo_ne   = (inflight_q != '0);
    head_idx  = ord_idx_q[rd_ptr_q];
    rsp_valid = '0;
    if (reset && fifo_ne && pe_rsp_valid) rsp_valid[head_idx] = 1'b1;
    pe_rsp_ready = reset && (fifo_ne ? rsp_ready[head_idx] : 1'b1);
    rsp_pop      = pe_rsp_valid && pe_rsp_ready && fifo_ne;
    rsp_data     = pe_rsp_data;
    rsp_tag      = ord_tag_q[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q       <= '0;
      iss_valid_q <= 1'b0;
      inflight_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      if (gnt_valid) begin
        ptr_q       <= (gnt_idx == IdxW'(NUM_REQS - 1)) ? '0 : gnt_idx + IdxW'(1);
        iss_valid_q <= 1'b1;
        wr_ptr_q    <= ptr_inc(wr_ptr_q);
      end else if (pe_req_ready) begin
        iss_valid_q <= 1'b0;
      end
      if (rsp_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (gnt_valid && !rsp_pop) begin
        inflight_q <= inflight_q + CntW'(1);
      end else if (!gnt_valid && rsp_pop) begin
        inflight_q <= inflight_q - CntW'(1);
      end
      if (pe_rsp_valid && !fifo_ne) err_q <= 1'b1;
    end
  end

  // Datapath storage needs no reset; validity is tracked by the control state above.
  always_ff @(posedge clk) begin
    if (gnt_valid) begin
      iss_a_q             <= req_a[gnt_idx];
      iss_b_q             <= req_b[gnt_idx];
      ord_idx_q[wr_ptr_q] <= gnt_idx;
      ord_tag_q[wr_ptr_q] <= req_tag[gnt_idx];
    end
  end

  assign pe_req_valid = iss_valid_q;
  assign pe_req_a     = iss_a_q;
  assign pe_req_b     = iss_b_q;
  assign inflight     = inflight_q;
  assign err          = err_q;

endmodule
